// File: rtl/pool2x2_relu_pkg.sv
// Shared word/lane geometry, BRAM strobe constants, FSM state type and
// the per-lane ReLU helper used by the 2x2 max-pool stage.
package pool2x2_relu_pkg;

  localparam int WORD_W          = 32;
  localparam int LANE_W          = 8;
  localparam int LANES           = 4;
  localparam int BYTE_ADDR_SHIFT = 2;

  localparam logic [3:0] BRAM_WE_ALL  = 4'hF;
  localparam logic [3:0] BRAM_WE_NONE = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  // Clamp every negative int8 lane of a packed word to zero.
  function automatic logic [WORD_W-1:0] relu_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    for (int k = 0; k < LANES; k++) begin
      if (w[k*LANE_W + LANE_W - 1]) begin
        r[k*LANE_W +: LANE_W] = '0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pool2x2_relu_lane_max.sv
// Combinational lane-wise signed int8 maximum of two packed 4-lane words.
module pool_lane_max
  import pool2x2_relu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);

  // Pick the larger signed value independently in each lane.
  always_comb begin
    y = '0;
    for (int k = 0; k < LANES; k++) begin
      y[k*LANE_W +: LANE_W] =
        ($signed(a[k*LANE_W +: LANE_W]) >= $signed(b[k*LANE_W +: LANE_W])) ?
        a[k*LANE_W +: LANE_W] : b[k*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/pool2x2_relu.sv
// 2x2 / stride-2 max-pool with optional ReLU. Reads a packed int8x4 feature
// map from one BRAM and writes the pooled map to another, one output word
// every six cycles (four reads, one capture, one write).
module pool2x2_relu
  import pool2x2_relu_pkg::*;
#(
  parameter int          IN_H      = 10,
  parameter int          IN_W      = 10,
  parameter int          CH_GROUPS = 4,
  parameter logic [31:0] SRC_BASE  = 32'h0,
  parameter logic [31:0] DST_BASE  = 32'h0,
  parameter int          RELU_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_SRC_ADDR,
  output logic        BRAM_SRC_EN,
  output logic [3:0]  BRAM_SRC_WE,
  output logic [31:0] BRAM_SRC_DIN,
  input  logic [31:0] BRAM_SRC_DOUT,
  output logic [31:0] BRAM_DST_ADDR,
  output logic        BRAM_DST_EN,
  output logic [3:0]  BRAM_DST_WE,
  output logic [31:0] BRAM_DST_DIN,
  input  logic [31:0] BRAM_DST_DOUT
);

  localparam int OUT_H = IN_H / 2;
  localparam int OUT_W = IN_W / 2;

  localparam logic [31:0] PLANE_WORDS = 32'(IN_H * IN_W);
  localparam logic [31:0] OUT_PLANE   = 32'(OUT_H * OUT_W);
  localparam logic [31:0] IN_W_W      = 32'(IN_W);
  localparam logic [31:0] OUT_W_W     = 32'(OUT_W);
  localparam logic [31:0] LAST_C      = 32'(OUT_W - 1);
  localparam logic [31:0] LAST_R      = 32'(OUT_H - 1);
  localparam logic [31:0] LAST_G      = 32'(CH_GROUPS - 1);

  state_t state, next_state;

  logic [31:0]       g_cnt, r_cnt, c_cnt;
  logic [31:0]       src_index, dst_index;
  logic [31:0]       dr, dc;
  logic [WORD_W-1:0] max_q, fold_y, pooled;
  logic              last_out;
  logic              unused_bits;

  assign last_out = (g_cnt == LAST_G) && (r_cnt == LAST_R) && (c_cnt == LAST_C);
  assign pooled   = (RELU_EN != 0) ? relu_word(max_q) : max_q;

  // The source BRAM is read-only and the destination read port is never used.
  assign BRAM_SRC_WE  = BRAM_WE_NONE;
  assign BRAM_SRC_DIN = '0;
  assign unused_bits  = ^{BRAM_DST_DOUT, r_cnt[31], c_cnt[31]};

  pool_lane_max u_lane_max (
    .a (max_q),
    .b (BRAM_SRC_DOUT),
    .y (fold_y)
  );

  // State register; reset drops straight to IDLE so no partial write escapes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Fixed six-cycle sequence per output window, then a one-cycle FIN.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  next_state = start ? S_RD0 : S_IDLE;
      S_RD0:   next_state = S_RD1;
      S_RD1:   next_state = S_RD2;
      S_RD2:   next_state = S_RD3;
      S_RD3:   next_state = S_CAP;
      S_CAP:   next_state = S_WR;
      S_WR:    next_state = last_out ? S_FIN : S_RD0;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output position counters: column fastest, then row, then channel group.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_cnt <= '0;
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      g_cnt <= '0;
      r_cnt <= '0;
      c_cnt <= '0;
    end else if (state == S_WR && !last_out) begin
      if (c_cnt == LAST_C) begin
        c_cnt <= '0;
        if (r_cnt == LAST_R) begin
          r_cnt <= '0;
          g_cnt <= g_cnt + 32'd1;
        end else begin
          r_cnt <= r_cnt + 32'd1;
        end
      end else begin
        c_cnt <= c_cnt + 32'd1;
      end
    end
  end

  // Running max: the first read word seeds the register, later ones fold in.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else begin
      unique case (state)
        S_RD1:                max_q <= BRAM_SRC_DOUT;
        S_RD2, S_RD3, S_CAP:  max_q <= fold_y;
        default:              max_q <= max_q;
      endcase
    end
  end

  // Word indices of the current 2x2 window tap and of the output word.
  always_comb begin
    dr = '0;
    dc = '0;
    unique case (state)
      S_RD1:   dc = 32'd1;
      S_RD2:   dr = 32'd1;
      S_RD3: begin
        dr = 32'd1;
        dc = 32'd1;
      end
      default: ;
    endcase
    src_index = g_cnt * PLANE_WORDS
              + ({r_cnt[30:0], 1'b0} + dr) * IN_W_W
              + {c_cnt[30:0], 1'b0} + dc;
    dst_index = g_cnt * OUT_PLANE + r_cnt * OUT_W_W + c_cnt;
  end

  // BRAM strobes and done decoded from state; idle buses are held at zero.
  always_comb begin
    done          = 1'b0;
    BRAM_SRC_EN   = 1'b0;
    BRAM_SRC_ADDR = '0;
    BRAM_DST_EN   = 1'b0;
    BRAM_DST_WE   = BRAM_WE_NONE;
    BRAM_DST_ADDR = '0;
    BRAM_DST_DIN  = '0;
    unique case (state)
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        BRAM_SRC_EN   = 1'b1;
        BRAM_SRC_ADDR = SRC_BASE + (src_index << BYTE_ADDR_SHIFT);
      end
      S_WR: begin
        BRAM_DST_EN   = 1'b1;
        BRAM_DST_WE   = BRAM_WE_ALL;
        BRAM_DST_ADDR = DST_BASE + (dst_index << BYTE_ADDR_SHIFT);
        BRAM_DST_DIN  = pooled;
      end
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pool2x2_relu.sv
// Directed bench for pool2x2_relu: three instances (10x10x4 ReLU, 2x2x1 no
// ReLU, 5x5x1 ReLU) each with behavioural source/destination BRAMs.
module tb_pool2x2_relu;

  localparam logic [31:0] SENTINEL = 32'h5A5A_5A5A;
  localparam int          LIMIT    = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] done_v;
  logic [2:0] clr_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instance A: 10x10x4, ReLU on
  logic [31:0] a_saddr, a_sdin, a_sdout, a_daddr, a_ddin, a_ddout;
  logic        a_sen, a_den;
  logic [3:0]  a_swe, a_dwe;
  logic [31:0] mem_a_src [400];
  logic [31:0] mem_a_dst [100];
  logic [31:0] exp_a     [100];

  // Instance B: 2x2x1, ReLU off
  logic [31:0] b_saddr, b_sdin, b_sdout, b_daddr, b_ddin, b_ddout;
  logic        b_sen, b_den;
  logic [3:0]  b_swe, b_dwe;
  logic [31:0] mem_b_src [4];
  logic [31:0] mem_b_dst [1];

  // Instance C: 5x5x1, ReLU on
  logic [31:0] c_saddr, c_sdin, c_sdout, c_daddr, c_ddin, c_ddout;
  logic        c_sen, c_den;
  logic [3:0]  c_swe, c_dwe;
  logic [31:0] mem_c_src [25];
  logic [31:0] mem_c_dst [4];

  assign a_ddout = 32'hDEAD_BEEF;
  assign b_ddout = 32'hDEAD_BEEF;
  assign c_ddout = 32'hDEAD_BEEF;

  pool2x2_relu #(.IN_H(10), .IN_W(10), .CH_GROUPS(4), .SRC_BASE(32'h0), .DST_BASE(32'h0), .RELU_EN(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .done(done_v[0]),
    .BRAM_SRC_ADDR(a_saddr), .BRAM_SRC_EN(a_sen), .BRAM_SRC_WE(a_swe), .BRAM_SRC_DIN(a_sdin), .BRAM_SRC_DOUT(a_sdout),
    .BRAM_DST_ADDR(a_daddr), .BRAM_DST_EN(a_den), .BRAM_DST_WE(a_dwe), .BRAM_DST_DIN(a_ddin), .BRAM_DST_DOUT(a_ddout)
  );

  pool2x2_relu #(.IN_H(2), .IN_W(2), .CH_GROUPS(1), .SRC_BASE(32'h0), .DST_BASE(32'h0), .RELU_EN(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .done(done_v[1]),
    .BRAM_SRC_ADDR(b_saddr), .BRAM_SRC_EN(b_sen), .BRAM_SRC_WE(b_swe), .BRAM_SRC_DIN(b_sdin), .BRAM_SRC_DOUT(b_sdout),
    .BRAM_DST_ADDR(b_daddr), .BRAM_DST_EN(b_den), .BRAM_DST_WE(b_dwe), .BRAM_DST_DIN(b_ddin), .BRAM_DST_DOUT(b_ddout)
  );

  pool2x2_relu #(.IN_H(5), .IN_W(5), .CH_GROUPS(1), .SRC_BASE(32'h0), .DST_BASE(32'h0), .RELU_EN(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .done(done_v[2]),
    .BRAM_SRC_ADDR(c_saddr), .BRAM_SRC_EN(c_sen), .BRAM_SRC_WE(c_swe), .BRAM_SRC_DIN(c_sdin), .BRAM_SRC_DOUT(c_sdout),
    .BRAM_DST_ADDR(c_daddr), .BRAM_DST_EN(c_den), .BRAM_DST_WE(c_dwe), .BRAM_DST_DIN(c_ddin), .BRAM_DST_DOUT(c_ddout)
  );

  // Behavioural BRAMs: one-cycle read latency, full-word writes, bench-driven clear
  always @(posedge clk) begin
    if (a_sen && a_saddr[31:2] < 400) a_sdout <= mem_a_src[a_saddr[31:2]];
    if (b_sen && b_saddr[31:2] < 4)   b_sdout <= mem_b_src[b_saddr[31:2]];
    if (c_sen && c_saddr[31:2] < 25)  c_sdout <= mem_c_src[c_saddr[31:2]];
    if (clr_v[0]) begin
      for (int i = 0; i < 100; i++) mem_a_dst[i] <= SENTINEL;
    end else if (a_den && a_dwe == 4'hF && a_daddr[31:2] < 100) begin
      mem_a_dst[a_daddr[31:2]] <= a_ddin;
    end
    if (clr_v[1]) begin
      mem_b_dst[0] <= SENTINEL;
    end else if (b_den && b_dwe == 4'hF && b_daddr[31:2] < 1) begin
      mem_b_dst[b_daddr[31:2]] <= b_ddin;
    end
    if (clr_v[2]) begin
      for (int i = 0; i < 4; i++) mem_c_dst[i] <= SENTINEL;
    end else if (c_den && c_dwe == 4'hF && c_daddr[31:2] < 4) begin
      mem_c_dst[c_daddr[31:2]] <= c_ddin;
    end
  end

  // Bus monitors: read/write overlap, reads of the dropped odd row/col, A write count
  int overlap_cnt = 0;
  int c_bad_reads = 0;
  int a_writes    = 0;
  always @(negedge clk) begin
    if ((a_sen && a_den) || (b_sen && b_den) || (c_sen && c_den)) overlap_cnt++;
    if (c_sen && ((c_saddr[31:2] / 5) == 4 || (c_saddr[31:2] % 5) == 4)) c_bad_reads++;
    if (a_den) a_writes++;
  end

  typedef struct {
    logic [31:0] w [4];
    logic [31:0] expect_out;
    string       name;
  } vec_t;

  vec_t vecs [6];

  // Independent lane-wise reference of pool + optional ReLU
  function automatic logic [31:0] pool_model(input logic [31:0] w0, w1, w2, w3, input bit relu);
    logic [31:0]       ws [4];
    logic [31:0]       res;
    logic signed [7:0] best, cand;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      best = ws[0][k*8 +: 8];
      for (int j = 1; j < 4; j++) begin
        cand = ws[j][k*8 +: 8];
        if (cand > best) best = cand;
      end
      if (relu && best < 0) best = 8'sd0;
      res[k*8 +: 8] = best;
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Pulse start on one instance (caller is just past a posedge) and count
  // edges until done is seen; -1 when the bound runs out.
  task automatic applyStimulus(input int which, output int cycles);
    start_v[which] = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      start_v[which] = 1'b0;
      cycles++;
    end while (!done_v[which] && cycles < LIMIT);
    if (!done_v[which]) cycles = -1;
  endtask

  task automatic clearDst(input int which);
    clr_v[which] = 1'b1;
    @(posedge clk); #1;
    clr_v[which] = 1'b0;
  endtask

  task automatic fillA(input bit negative);
    for (int i = 0; i < 400; i++) begin
      mem_a_src[i] = negative ? ($urandom | 32'h8080_8080) : $urandom;
    end
    for (int g = 0; g < 4; g++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          exp_a[g*25 + r*5 + c] = pool_model(
            mem_a_src[g*100 + (2*r)*10 + 2*c],     mem_a_src[g*100 + (2*r)*10 + 2*c + 1],
            mem_a_src[g*100 + (2*r+1)*10 + 2*c],   mem_a_src[g*100 + (2*r+1)*10 + 2*c + 1], 1'b1);
        end
  endtask

  task automatic checkA(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      n_cmp++;
      if (mem_a_dst[i] !== exp_a[i]) begin
        n_fail++;
        bad++;
        if (bad <= 4) $display("[TB] FAIL %s word %0d: got %h, expected %h", tag, i, mem_a_dst[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    int cyc, w0, sbad, sbefore;
    logic [31:0] exp_c [4];

    vecs[0] = '{w: '{32'h7F800102, 32'h00810203, 32'h01000304, 32'h02010405}, expect_out: 32'h7F010405, name: "fold"};
    vecs[1] = '{w: '{32'h80FF8090, 32'hFF80A0B0, 32'h90A0FFC0, 32'hA0B0C0FF}, expect_out: 32'hFFFFFFFF, name: "neg_norelu"};
    vecs[2] = '{w: '{32'h80808080, 32'h81818181, 32'h80808080, 32'h80808080}, expect_out: 32'h81818181, name: "m128_loses"};
    vecs[3] = '{w: '{32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080}, expect_out: 32'h80808080, name: "all_m128"};
    vecs[4] = '{w: '{32'h00000000, 32'hFF01FF01, 32'h01FF01FF, 32'h80808080}, expect_out: 32'h01010101, name: "mixed"};
    vecs[5] = '{w: '{32'h10203040, 32'h11213141, 32'h12223242, 32'h7F7F7F7F}, expect_out: 32'h7F7F7F7F, name: "max_last"};

    rst = 1'b1;
    start_v = '0;
    clr_v = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_done",     {31'd0, done_v[0]}, 32'd0);
    checkOutput("rst_src_en",   {31'd0, a_sen},     32'd0);
    checkOutput("rst_dst_en",   {31'd0, a_den},     32'd0);
    checkOutput("rst_dst_we",   {28'd0, a_dwe},     32'd0);
    checkOutput("rst_src_addr", a_saddr,            32'd0);
    checkOutput("rst_dst_din",  a_ddin,             32'd0);
    checkOutput("src_we_tied",  {28'd0, a_swe},     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of single-window folds on the 2x2x1 no-ReLU instance
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) mem_b_src[j] = vecs[i].w[j];
      clearDst(1);
      applyStimulus(1, cyc);
      checkOutput({vecs[i].name, "_cycles"}, cyc, 7);
      checkOutput(vecs[i].name, mem_b_dst[0], vecs[i].expect_out);
      @(posedge clk); #1;
    end

    // All-negative layer with ReLU clamps to zero
    fillA(1'b1);
    for (int i = 0; i < 100; i++) checkOutput("neg_model", exp_a[i], 32'h0);
    clearDst(0);
    applyStimulus(0, cyc);
    checkOutput("neg_cycles", cyc, 601);
    checkA("neg_relu");
    @(posedge clk); #1;

    // Full random layer
    fillA(1'b0);
    clearDst(0);
    applyStimulus(0, cyc);
    checkOutput("full_cycles", cyc, 601);
    checkA("full");
    @(posedge clk); #1;

    // Odd 5x5x1: row/col 4 carry 7F7F7F7F and must never be read
    for (int i = 0; i < 25; i++) begin
      mem_c_src[i] = ((i / 5) == 4 || (i % 5) == 4) ? 32'h7F7F7F7F : ($urandom & 32'h7E7E7E7E);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        exp_c[r*2 + c] = pool_model(mem_c_src[(2*r)*5 + 2*c], mem_c_src[(2*r)*5 + 2*c + 1],
                                    mem_c_src[(2*r+1)*5 + 2*c], mem_c_src[(2*r+1)*5 + 2*c + 1], 1'b1);
    clearDst(2);
    sbad = c_bad_reads;
    applyStimulus(2, cyc);
    checkOutput("odd_cycles", cyc, 25);
    for (int i = 0; i < 4; i++) checkOutput("odd_word", mem_c_dst[i], exp_c[i]);
    checkOutput("odd_no_edge_read", c_bad_reads - sbad, 0);
    @(posedge clk); #1;

    // Start pulses while busy must not disturb the run
    fillA(1'b0);
    clearDst(0);
    start_v[0] = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      start_v[0] = (cyc == 3 || cyc == 50 || cyc == 300);
    end while (!done_v[0] && cyc < LIMIT);
    start_v[0] = 1'b0;
    checkOutput("busy_cycles", cyc, 601);
    checkA("busy");
    // A start raised during the done cycle is ignored as well
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    sbad = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_sen || done_v[0]) sbad++;
      @(posedge clk); #1;
    end
    checkOutput("done_cycle_start_ignored", sbad, 0);

    // Reset in cycle 20 of a run
    fillA(1'b0);
    clearDst(0);
    sbefore = a_writes;
    start_v[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_src_en", {31'd0, a_sen},     32'd0);
    checkOutput("midrst_dst_en", {31'd0, a_den},     32'd0);
    checkOutput("midrst_done",   {31'd0, done_v[0]}, 32'd0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midrst_writes", a_writes - sbefore, 3);
    for (int i = 0; i < 3; i++) checkOutput("midrst_kept", mem_a_dst[i], exp_a[i]);
    checkOutput("midrst_no_stray", mem_a_dst[3], SENTINEL);
    checkOutput("midrst_done_low", {31'd0, done_v[0]}, 32'd0);
    applyStimulus(0, cyc);
    checkOutput("after_rst_cycles", cyc, 601);
    checkA("after_rst");

    // Back-to-back: destination cleared in the idle cycle, start right after FIN
    clearDst(0);
    applyStimulus(0, cyc);
    checkOutput("b2b_cycles", cyc, 601);
    checkA("b2b");

    checkOutput("no_en_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
